// File: rtl/mem_row_ctrl.sv
// Open-page row controller: caches one 64-word core row, serving hits from the buffer.
// Define MEM_ROW_CTRL_AUTO_PRECHARGE_EN to close the row after every access (write-back if dirty).
module mem_row_ctrl #(
   parameter int ROW_ADDR_BITWIDTH = 8,
   parameter int COL_ADDR_BITWIDTH = 6,
   parameter int DATA_BIT_WIDTH    = 32
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                req_valid,
   output logic                                                req_ready,
   input  logic                                                req_we,
   input  logic [ROW_ADDR_BITWIDTH-1:0]                        req_row,
   input  logic [COL_ADDR_BITWIDTH-1:0]                        req_col,
   input  logic [DATA_BIT_WIDTH-1:0]                           req_wdata,
   output logic [DATA_BIT_WIDTH-1:0]                           rdata,
   output logic                                                rvalid,
   output logic                                                wack,
   output logic [(2**ROW_ADDR_BITWIDTH)-1:0]                   RowAddrEn,
   output logic                                                RE,
   output logic                                                WE,
   output logic [(2**COL_ADDR_BITWIDTH)*DATA_BIT_WIDTH-1:0]    CoreDataIn,
   input  logic [(2**COL_ADDR_BITWIDTH)*DATA_BIT_WIDTH-1:0]    CoreDataOut
);

   localparam int NUM_ROWS  = 2**ROW_ADDR_BITWIDTH;
   localparam int NUM_WORDS = 2**COL_ADDR_BITWIDTH;

   typedef enum logic [2:0] {IDLE, WRBACK, ACT, ACT_WAIT, ACCESS} state_t;

   state_t                                    state_q;
   logic [ROW_ADDR_BITWIDTH-1:0]              open_row_q;
   logic                                      open_valid_q;
   logic                                      dirty_q;
   logic                                      lat_we_q;
   logic [ROW_ADDR_BITWIDTH-1:0]              lat_row_q;
   logic [COL_ADDR_BITWIDTH-1:0]              lat_col_q;
   logic [DATA_BIT_WIDTH-1:0]                 lat_wdata_q;
   logic [DATA_BIT_WIDTH-1:0]                 rdata_q;
   logic                                      rvalid_q;
   logic                                      wack_q;
   logic                                      re_q;
   logic                                      we_q;
   logic [NUM_ROWS-1:0]                       row_en_q;
   logic [NUM_WORDS-1:0][DATA_BIT_WIDTH-1:0]  row_buf_q;

   function automatic logic [NUM_ROWS-1:0] onehot(input logic [ROW_ADDR_BITWIDTH-1:0] r);
      logic [NUM_ROWS-1:0] v;
      v    = '0;
      v[r] = 1'b1;
      return v;
   endfunction

   // Core strobes are registered on the edge entering the state that owns them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         open_row_q   <= '0;
         open_valid_q <= 1'b0;
         dirty_q      <= 1'b0;
         lat_we_q     <= 1'b0;
         lat_row_q    <= '0;
         lat_col_q    <= '0;
         lat_wdata_q  <= '0;
         rdata_q      <= '0;
         rvalid_q     <= 1'b0;
         wack_q       <= 1'b0;
         re_q         <= 1'b0;
         we_q         <= 1'b0;
         row_en_q     <= '0;
      end else begin
         rvalid_q <= 1'b0;
         wack_q   <= 1'b0;
         re_q     <= 1'b0;
         we_q     <= 1'b0;
         row_en_q <= '0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  lat_we_q    <= req_we;
                  lat_row_q   <= req_row;
                  lat_col_q   <= req_col;
                  lat_wdata_q <= req_wdata;
                  if (open_valid_q && (req_row == open_row_q)) begin
                     state_q <= ACCESS;
                  end else if (dirty_q) begin
                     state_q  <= WRBACK;
                     we_q     <= 1'b1;
                     row_en_q <= onehot(open_row_q);
                  end else begin
                     state_q  <= ACT;
                     re_q     <= 1'b1;
                     row_en_q <= onehot(req_row);
                  end
               end
            end
            WRBACK: begin
               dirty_q <= 1'b0;
`ifdef MEM_ROW_CTRL_AUTO_PRECHARGE_EN
               state_q      <= IDLE;
               open_valid_q <= 1'b0;
`else
               state_q  <= ACT;
               re_q     <= 1'b1;
               row_en_q <= onehot(lat_row_q);
`endif
            end
            ACT: state_q <= ACT_WAIT;
            ACT_WAIT: begin
               open_row_q   <= lat_row_q;
               open_valid_q <= 1'b1;
               state_q      <= ACCESS;
            end
            ACCESS: begin
               if (lat_we_q) begin
                  dirty_q <= 1'b1;
                  wack_q  <= 1'b1;
               end else begin
                  rdata_q  <= row_buf_q[lat_col_q];
                  rvalid_q <= 1'b1;
               end
`ifdef MEM_ROW_CTRL_AUTO_PRECHARGE_EN
               // Only a write can leave the buffer dirty; close the row right away.
               if (lat_we_q) begin
                  state_q  <= WRBACK;
                  we_q     <= 1'b1;
                  row_en_q <= onehot(open_row_q);
               end else begin
                  state_q      <= IDLE;
                  open_valid_q <= 1'b0;
               end
`else
               state_q <= IDLE;
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Buffer data is never reset; open_valid_q alone decides whether it is meaningful.
   always_ff @(posedge clk) begin
      if (state_q == ACT_WAIT)
         row_buf_q <= CoreDataOut;
      else if ((state_q == ACCESS) && lat_we_q)
         row_buf_q[lat_col_q] <= lat_wdata_q;
   end

   assign req_ready  = (state_q == IDLE);
   assign rdata      = rdata_q;
   assign rvalid     = rvalid_q;
   assign wack       = wack_q;
   assign RE         = re_q;
   assign WE         = we_q;
   assign RowAddrEn  = row_en_q;
   assign CoreDataIn = row_buf_q;

endmodule

// File: tb/tb_mem_row_ctrl.sv
// Directed bench for mem_row_ctrl with a behavioural row-memory core model.
module tb_mem_row_ctrl;
   localparam int RB = 8;
   localparam int CB = 6;
   localparam int DW = 32;
   localparam int NR = 256;
   localparam int NW = 64;
   localparam int RW = NW*DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_we;
   logic [RB-1:0] req_row;
   logic [CB-1:0] req_col;
   logic [DW-1:0] req_wdata, rdata;
   logic          rvalid, wack, RE, WE;
   logic [NR-1:0] RowAddrEn;
   logic [RW-1:0] CoreDataIn, CoreDataOut;

   always #5 clk = ~clk;

   mem_row_ctrl #(.ROW_ADDR_BITWIDTH(RB), .COL_ADDR_BITWIDTH(CB), .DATA_BIT_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata), .rdata(rdata),
      .rvalid(rvalid), .wack(wack), .RowAddrEn(RowAddrEn), .RE(RE), .WE(WE),
      .CoreDataIn(CoreDataIn), .CoreDataOut(CoreDataOut));

   function automatic logic [DW-1:0] pat(input int r, input int k);
      logic [DW-1:0] v;
      if (r == 5 && k == 3) return 32'hDEADBEEF;
      v = 32'hA000_0000 + 32'(r*256) + 32'(k);
      return v;
   endfunction

   function automatic logic [RW-1:0] row_init(input int r);
      logic [RW-1:0] v;
      for (int k = 0; k < NW; k++) v[k*DW +: DW] = pat(r, k);
      return v;
   endfunction

   function automatic int oh_idx(input logic [NR-1:0] v);
      int idx = -1;
      for (int i = 0; i < NR; i++) if (v[i]) idx = i;
      return idx;
   endfunction

   // Core model: unwritten rows read back their init pattern.
   logic [RW-1:0] core_mem [NR];
   bit            core_wr  [NR];
   always @(posedge clk) begin
      for (int r = 0; r < NR; r++) begin
         if (RE && RowAddrEn[r]) CoreDataOut <= core_wr[r] ? core_mem[r] : row_init(r);
         if (WE && RowAddrEn[r]) begin
            core_mem[r] <= CoreDataIn;
            core_wr[r]  <= 1'b1;
         end
      end
   end

   int            re_cnt = 0, we_cnt = 0, both_cnt = 0, bad_oh = 0, re_row = -1, we_row = -1;
   logic [DW-1:0] we_word3 = '0;
   always @(posedge clk) begin
      if (!rst) begin
         if (RE) begin re_cnt <= re_cnt + 1; re_row <= oh_idx(RowAddrEn); end
         if (WE) begin we_cnt <= we_cnt + 1; we_row <= oh_idx(RowAddrEn); we_word3 <= CoreDataIn[3*DW +: DW]; end
         if (RE && WE) both_cnt <= both_cnt + 1;
         if ((RE || WE) ? ($countones(RowAddrEn) != 1) : (RowAddrEn != '0)) bad_oh <= bad_oh + 1;
      end
   end

   int n_pass = 0, n_total = 0;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic req(input logic we, input int row, input int col, input logic [DW-1:0] wd, input string tag);
      chk({tag, " ready"}, req_ready, 1);
      req_valid = 1'b1; req_we = we; req_row = row[RB-1:0]; req_col = col[CB-1:0]; req_wdata = wd;
      tick();
      req_valid = 1'b0; req_we = 1'b0; req_wdata = 32'h0BAD_0BAD;
   endtask

   task automatic wait_resp(output int lat);
      lat = 1;
      while (!(rvalid || wack) && lat < 20) begin tick(); lat++; end
   endtask

   task automatic run(input logic we, input int row, input int col, input logic [DW-1:0] d,
                      input int exp_lat, input string tag);
      int lat;
      req(we, row, col, d, tag);
      wait_resp(lat);
      chk({tag, " latency"}, lat, exp_lat);
      if (we) chk({tag, " rvalid/wack"}, {rvalid, wack}, 2'b01);
      else begin
         chk({tag, " rvalid/wack"}, {rvalid, wack}, 2'b10);
         chk({tag, " rdata"}, rdata, d);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int            r0, w0, lat;
      logic [NR-1:0] oh;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_row = '0; req_col = '0; req_wdata = '0;
      tick(); tick();
      chk("rst strobes", {rvalid, wack, RE, WE}, 4'b0000);
      chk("rst rowen", RowAddrEn === '0, 1);
      chk("rst rdata", rdata, 0);
      rst = 1'b0;
      chk("ready after rst", req_ready, 1);

`ifdef MEM_ROW_CTRL_AUTO_PRECHARGE_EN
      r0 = re_cnt; w0 = we_cnt;
      run(0, 2, 1, pat(2, 1), 4, "ap rd1");
      run(0, 2, 1, pat(2, 1), 4, "ap rd2");
      chk("ap two acts", re_cnt - r0, 2);
      run(1, 2, 4, 32'h1357_2468, 4, "ap wr");
      oh = '0; oh[2] = 1'b1;
      chk("ap wrback ready", req_ready, 0);
      chk("ap wrback WE", WE, 1);
      chk("ap wrback rowen", RowAddrEn === oh, 1);
      tick();
      run(0, 2, 4, 32'h1357_2468, 4, "ap rd back");
      chk("ap one wrback", we_cnt - w0, 1);
`else
      // Clean miss on row 5
      r0 = re_cnt; w0 = we_cnt;
      req(0, 5, 3, '0, "miss5");
      oh = '0; oh[5] = 1'b1;
      chk("miss5 RE t+1", RE, 1);
      chk("miss5 rowen t+1", RowAddrEn === oh, 1);
      wait_resp(lat);
      chk("miss5 latency", lat, 4);
      chk("miss5 rdata", rdata, 32'hDEADBEEF);
      chk("miss5 core ops", {re_cnt - r0, we_cnt - w0}, {32'd1, 32'd0});

      // Write hit then back-to-back read hit
      r0 = re_cnt; w0 = we_cnt;
      run(1, 5, 3, 32'h1234_5678, 2, "wr hit");
      run(0, 5, 3, 32'h1234_5678, 2, "rd hit");
      chk("hits no core ops", {re_cnt - r0, we_cnt - w0}, 64'd0);
      tick();
      chk("rvalid drops", rvalid, 0);
      chk("rdata holds", rdata, 32'h1234_5678);

      // Dirty miss to row 9
      r0 = re_cnt; w0 = we_cnt;
      run(0, 9, 0, pat(9, 0), 5, "dirty miss");
      chk("wb count", we_cnt - w0, 1);
      chk("wb row", we_row, 5);
      chk("wb word3", we_word3, 32'h1234_5678);
      chk("act count", re_cnt - r0, 1);
      chk("act row", re_row, 9);
      run(0, 9, 7, pat(9, 7), 2, "hit9");
      run(1, 9, 1, 32'hCAFE_F00D, 2, "wr9");

      // Reset during ACT_WAIT of a dirty miss
      req(0, 20, 0, '0, "abort");
      chk("abort WE t+1", WE, 1);
      tick(); tick();
      chk("abort in act_wait", {RE, WE, rvalid}, 3'b000);
      rst = 1'b1; #1;
      chk("async rst strobes", {RE, WE, rvalid, wack}, 4'b0000);
      chk("async rst ready", req_ready, 1);
      tick();
      rst = 1'b0;
      chk("ready after abort", req_ready, 1);
      w0 = we_cnt; r0 = re_cnt;
      run(0, 9, 1, 32'hCAFE_F00D, 4, "rd9 after rst");
      run(0, 20, 2, pat(20, 2), 4, "rd20 miss");
      run(1, 20, 2, 32'h55AA_55AA, 2, "wr20 hit");
      rst = 1'b1; tick(); rst = 1'b0;
      run(0, 20, 2, pat(20, 2), 4, "rd20 discarded");
      chk("no wb after rst", we_cnt - w0, 0);
      chk("act count after rst", re_cnt - r0, 3);
      run(0, 5, 3, 32'h1234_5678, 4, "core row5");
`endif
      chk("RE&WE never", both_cnt, 0);
      chk("rowen onehot", bad_oh, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
